linebuffer9_window: RTL and testbench
=====================================

Name: linebuffer9_window

Overview:
- Streaming 9x9 window generator. Sits directly upstream of the 81-tap inner-product stage in the line-buffer logistic-regression pipeline.
- Accepts raster-order pixels one per cycle and stores the previous 8 image rows in line buffers.
- Each time a full 9x9 neighbourhood is available, it presents all 81 pixels in parallel with a valid strobe.
- The inner-product stage consumes the window combinationally.

Parameters:
- IMG_W, 28, image width in pixels (>= 9)
- IMG_H, 28, image height in rows (>= 9)
- PIX_W, 7, pixel width in bits (matches the inner-product xarray element width)
- K, 9, window edge; fixed at 9 for this release, other values unsupported

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pix_in  in  PIX_W  incoming pixel, raster order
- pix_valid  in  1  pix_in is accepted this cycle when high
- sof  in  1  start of frame; qualifies the pix_valid pixel as row 0, col 0
- win_out  out  K*K*PIX_W  flattened window; element i = row (i/9), col (i%9); bits [i*PIX_W +: PIX_W]
- win_valid  out  1  one-cycle pulse; win_out holds a complete window
- win_row  out  $clog2(IMG_H)  image row of the window's bottom-right pixel
- win_col  out  $clog2(IMG_W)  image column of the window's bottom-right pixel
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset (async assert, sync release): col_cnt=0, row_cnt=0, win_valid=0, frame_done=0, win_out=0, win_row=0, win_col=0, window registers=0. Line-buffer RAM contents are don't-care.
- Accept: an accept is any cycle with pix_valid=1. With pix_valid=0, all state holds (stall) and win_out stays stable.
- sof with pix_valid:
  - forces this pixel to row 0, col 0; counters restart from it.
  - a partial frame in progress is abandoned with no frame_done.
- sof without pix_valid is ignored.
- Line buffers: 8 row FIFOs of depth IMG_W, cascaded.
  - On accept, buffer 0 takes pix_in, and buffer j takes buffer j-1's output.
  - Per accept, the 9 column pixels = {buf7_out .. buf0_out, pix_in}, oldest row first.
- Window: 9x9 register array.
  - On accept, each row shifts left one column; the new column enters at col 8.
  - Element 0 = top-left (oldest row, oldest column); element 80 = current pixel.
- Counters on accept:
  - col_cnt increments and wraps at IMG_W-1 to 0.
  - On wrap, row_cnt increments and wraps at IMG_H-1 to 0.
- win_valid:
  - Registered; asserted the cycle after an accept whose (row_cnt>=8 and col_cnt>=8), evaluated before increment.
  - win_row/win_col latch that pixel's coordinates.
  - Latency 1 cycle from accept to win_valid.
  - Windows straddling a row boundary (col<8) are never flagged.
- Window count per frame is exactly (IMG_H-8)*(IMG_W-8); 400 for the defaults.
- frame_done:
  - Registered pulse the cycle after accepting (IMG_H-1, IMG_W-1), coincident with that final win_valid.
  - The next accept is row 0 of a new frame, whether or not sof is given.
- Stale line-buffer data from a previous frame never reaches a valid window, because row gating blocks it.
- Reset mid-frame: all outputs drop immediately; the next frame starts at row 0, col 0.
- Arithmetic: counters are unsigned. No saturation is needed; pixels pass through unmodified.

Decomposition:
- Shared package linebuf_pkg holds:
  - K=9 and PIX_W=7
  - NTAPS=81
  - localparam function win_idx(row, col)=row*9+col, so the inner-product stage uses identical flattening.
- One sub-module, linebuf_row: single-port circular row FIFO of depth IMG_W, width PIX_W, with shift enable.
  - Uses a read-before-write pointer and one wrap counter.
  - Instantiated 8 times.

Test Plan:
- Ramp frame, 28x28, pixel value = (r*28+c) mod 128, continuous valid.
  - First win_valid is 1 cycle after accept index 8*28+8=232, with win_row=8, win_col=8.
  - Element 0=0, element 80=(232 mod 128)=104.
  - Exactly 400 win_valid pulses.
- Same frame with pseudo-random pix_valid gaps (about 40% idle).
  - Window contents and count are identical to the ungapped run.
  - win_out is unchanged during stalls.
- Row boundary: across the whole frame, no win_valid for any col_cnt<8.
  - Last window of row 8 has win_col=27; the next win_valid has win_row=9, win_col=8.
- frame_done: pulses once, coincident with the 400th win_valid.
  - Back-to-back second frame without sof yields another 400 identical windows.
- sof mid-frame at row 12, col 5.
  - No frame_done; next win_valid occurs at new row 8, col 8 with fresh data only.
- rst_n asserted mid-frame (row 15).
  - win_valid and frame_done go 0 asynchronously.
  - After release, the frame restarts and the first window appears after 232 accepts.

Source files
------------

// File: rtl/linebuf_pkg.sv
// Shared constants for the 9x9 window generator and the downstream 81-tap stage.
// win_idx defines the one flattening order both sides agree on.
package linebuf_pkg;
  localparam int K     = 9;
  localparam int PIX_W = 7;
  localparam int NTAPS = K * K;

  function automatic int win_idx(input int row, input int col);
    return row * K + col;
  endfunction
endpackage

// File: rtl/linebuffer9_window_if.sv
// Pixel stream in, parallel 9x9 window out.
// The master drives pixels and the slave (the window generator) drives the window side.
interface linebuffer9_window_if
  import linebuf_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int PIX_W = linebuf_pkg::PIX_W
) ();
  logic [PIX_W-1:0]           pix_in;
  logic                       pix_valid;
  logic                       sof;
  logic [NTAPS*PIX_W-1:0]     win_out;
  logic                       win_valid;
  logic [$clog2(IMG_H)-1:0]   win_row;
  logic [$clog2(IMG_W)-1:0]   win_col;
  logic                       frame_done;

  modport master (output pix_in, pix_valid, sof,
                  input  win_out, win_valid, win_row, win_col, frame_done);
  modport slave  (input  pix_in, pix_valid, sof,
                  output win_out, win_valid, win_row, win_col, frame_done);
endinterface

// File: rtl/linebuf_row.sv
// One image row of delay: circular buffer that returns the pixel written DEPTH shifts ago.
// Read happens before write at the same pointer, so output is valid combinationally.
module linebuf_row #(
  parameter int DEPTH = 28,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_ptr;

  assign o_dout = r_mem[r_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + AW'(1);
    end
  end

  // Contents are don't-care after reset; row gating keeps stale data out of valid windows.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[r_ptr] <= i_din;
    end
  end
endmodule

// File: rtl/linebuffer9_window.sv
// Streaming 9x9 window generator: eight cascaded row buffers feed a 9x9 shift-register window.
// A window is flagged only when the newest pixel sits at row>=8 and col>=8.
module linebuffer9_window
  import linebuf_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int PIX_W = linebuf_pkg::PIX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  linebuffer9_window_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]    r_col_cnt, r_win_col, w_col;
  logic [RW-1:0]    r_row_cnt, r_win_row, w_row;
  logic             r_win_valid, r_frame_done;
  logic             w_acc, w_last_col, w_last_row, w_win_hit;
  logic [PIX_W-1:0] w_buf_out [K-1];
  logic [PIX_W-1:0] w_col_pix [K];
  logic [PIX_W-1:0] r_win [K][K];
  logic [NTAPS*PIX_W-1:0] w_win_flat;

  // sof re-labels the accepted pixel as (0,0) without touching the buffers.
  always_comb begin
    w_acc      = bus.pix_valid;
    w_col      = bus.sof ? '0 : r_col_cnt;
    w_row      = bus.sof ? '0 : r_row_cnt;
    w_last_col = (w_col == CW'(IMG_W - 1));
    w_last_row = (w_row == RW'(IMG_H - 1));
    w_win_hit  = (w_row >= RW'(K - 1)) && (w_col >= CW'(K - 1));
  end

  for (genvar j = 0; j < K - 1; j++) begin : g_row
    logic [PIX_W-1:0] w_din;
    if (j == 0) begin : g_first
      assign w_din = bus.pix_in;
    end else begin : g_next
      assign w_din = w_buf_out[j-1];
    end
    linebuf_row #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_row (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (w_acc),
      .i_din  (w_din),
      .o_dout (w_buf_out[j])
    );
    assign w_col_pix[K-2-j] = w_buf_out[j];
  end
  assign w_col_pix[K-1] = bus.pix_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_cnt    <= '0;
      r_row_cnt    <= '0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_win_row    <= '0;
      r_win_col    <= '0;
    end else begin
      r_win_valid  <= w_acc && w_win_hit;
      r_frame_done <= w_acc && w_last_row && w_last_col;
      if (w_acc) begin
        r_col_cnt <= w_last_col ? '0 : w_col + CW'(1);
        if (w_last_col) begin
          r_row_cnt <= w_last_row ? '0 : w_row + RW'(1);
        end else begin
          r_row_cnt <= w_row;
        end
        if (w_win_hit) begin
          r_win_row <= w_row;
          r_win_col <= w_col;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < K; k++) begin
        for (int c = 0; c < K; c++) begin
          r_win[k][c] <= '0;
        end
      end
    end else if (w_acc) begin
      for (int k = 0; k < K; k++) begin
        for (int c = 0; c < K - 1; c++) begin
          r_win[k][c] <= r_win[k][c+1];
        end
        r_win[k][K-1] <= w_col_pix[k];
      end
    end
  end

  always_comb begin
    w_win_flat = '0;
    for (int k = 0; k < K; k++) begin
      for (int c = 0; c < K; c++) begin
        w_win_flat[win_idx(k, c)*PIX_W +: PIX_W] = r_win[k][c];
      end
    end
  end

  assign bus.win_out    = w_win_flat;
  assign bus.win_valid  = r_win_valid;
  assign bus.win_row    = r_win_row;
  assign bus.win_col    = r_win_col;
  assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_linebuffer9_window.sv
// Self-checking bench for linebuffer9_window: a coordinate-indexed image model predicts
// every window, its coordinates, frame_done, and stall stability.
module tb_linebuffer9_window;
  localparam int W  = 28;
  localparam int H  = 28;
  localparam int PW = 7;
  localparam int WB = 81 * PW;

  logic clk;
  logic rst_n;

  linebuffer9_window_if #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) bus ();

  linebuffer9_window #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nAsserts = 0;
  int nFails   = 0;

  // Reference model state: pixels of the current frame by coordinate.
  logic [PW-1:0] img [H][W];
  int            mr = 0;
  int            mc = 0;
  int            acceptIdx = 0;
  int            dutWins = 0;
  logic          expWinKnown = 1'b0;
  logic [WB-1:0] lastWin = '0;

  task automatic applyStimulus(input logic [PW-1:0] p, input logic v, input logic s);
    @(negedge clk);
    bus.pix_in    = p;
    bus.pix_valid = v;
    bus.sof       = s;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input logic v, input logic s, input logic [PW-1:0] p);
    logic          expValid;
    logic          expDone;
    logic [WB-1:0] expWin;
    expWin = '0;
    if (v) begin
      if (s) begin
        mr = 0; mc = 0; acceptIdx = 0; dutWins = 0;
      end
      img[mr][mc] = p;
      expValid = (mr >= 8) && (mc >= 8);
      expDone  = (mr == H - 1) && (mc == W - 1);
      if (expValid) begin
        for (int i = 0; i < 81; i++) begin
          expWin[i*PW +: PW] = img[mr - 8 + i / 9][mc - 8 + i % 9];
        end
      end
      nAsserts++;
      assert (bus.win_valid === expValid) else begin
        nFails++;
        $error("[TB] FAIL win_valid at (%0d,%0d) obs=%0b exp=%0b", mr, mc, bus.win_valid, expValid);
      end
      nAsserts++;
      assert (bus.frame_done === expDone) else begin
        nFails++;
        $error("[TB] FAIL frame_done at (%0d,%0d) obs=%0b exp=%0b", mr, mc, bus.frame_done, expDone);
      end
      if (expValid) begin
        nAsserts++;
        assert (bus.win_row === 5'(mr)) else begin
          nFails++;
          $error("[TB] FAIL win_row obs=%0d exp=%0d", bus.win_row, mr);
        end
        nAsserts++;
        assert (bus.win_col === 5'(mc)) else begin
          nFails++;
          $error("[TB] FAIL win_col obs=%0d exp=%0d", bus.win_col, mc);
        end
        nAsserts++;
        assert (bus.win_out === expWin) else begin
          nFails++;
          $error("[TB] FAIL win_out at (%0d,%0d) obs=%h exp=%h", mr, mc, bus.win_out, expWin);
        end
      end
      if (bus.win_valid === 1'b1) begin
        if (dutWins == 0) begin
          nAsserts++;
          assert (acceptIdx === 232) else begin
            nFails++;
            $error("[TB] FAIL first_window_accept obs=%0d exp=%0d", acceptIdx, 232);
          end
        end
        dutWins++;
      end
      if (bus.frame_done === 1'b1) begin
        nAsserts++;
        assert (dutWins === 400) else begin
          nFails++;
          $error("[TB] FAIL window_count obs=%0d exp=%0d", dutWins, 400);
        end
      end
      expWinKnown = expValid;
      lastWin     = expWin;
      acceptIdx++;
      if (expDone) begin
        acceptIdx = 0;
        dutWins   = 0;
      end
      if (mc == W - 1) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end else begin
      nAsserts++;
      assert (bus.win_valid === 1'b0) else begin
        nFails++;
        $error("[TB] FAIL stall_win_valid obs=%0b exp=0", bus.win_valid);
      end
      nAsserts++;
      assert (bus.frame_done === 1'b0) else begin
        nFails++;
        $error("[TB] FAIL stall_frame_done obs=%0b exp=0", bus.frame_done);
      end
      if (expWinKnown) begin
        nAsserts++;
        assert (bus.win_out === lastWin) else begin
          nFails++;
          $error("[TB] FAIL stall_win_out obs=%h exp=%h", bus.win_out, lastWin);
        end
      end
    end
  endtask

  // Sends n accepted pixels of pattern (r*28+c+offset) mod 128, with random idle cycles.
  task automatic runPixels(input int n, input int gapPct, input int offset, input logic sofFirst);
    logic          s;
    int            r;
    int            c;
    logic [PW-1:0] p;
    for (int k = 0; k < n; k++) begin
      while ($urandom_range(99) < gapPct) begin
        applyStimulus(PW'($urandom_range(127)), 1'b0, 1'($urandom_range(1)));
        checkOutput(1'b0, 1'b0, '0);
      end
      s = sofFirst && (k == 0);
      r = s ? 0 : mr;
      c = s ? 0 : mc;
      p = PW'((r * W + c + offset) % 128);
      applyStimulus(p, 1'b1, s);
      checkOutput(1'b1, s, p);
    end
  endtask

  initial begin
    bus.pix_in    = '0;
    bus.pix_valid = 1'b0;
    bus.sof       = 1'b0;
    rst_n         = 1'b0;
    #13;
    nAsserts++;
    assert (bus.win_valid === 1'b0) else begin
      nFails++; $error("[TB] FAIL reset_win_valid obs=%0b exp=0", bus.win_valid);
    end
    nAsserts++;
    assert (bus.frame_done === 1'b0) else begin
      nFails++; $error("[TB] FAIL reset_frame_done obs=%0b exp=0", bus.frame_done);
    end
    nAsserts++;
    assert (bus.win_out === '0) else begin
      nFails++; $error("[TB] FAIL reset_win_out obs=%h exp=0", bus.win_out);
    end
    nAsserts++;
    assert (bus.win_row === 5'd0 && bus.win_col === 5'd0) else begin
      nFails++; $error("[TB] FAIL reset_coords obs=%0d,%0d exp=0,0", bus.win_row, bus.win_col);
    end
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] ramp frame, continuous valid");
    runPixels(W * H, 0, 0, 1'b1);
    $display("[TB] second frame without sof, 40%% idle gaps");
    runPixels(W * H, 40, 0, 1'b0);
    $display("[TB] sof abandons frame at row 12 col 5");
    runPixels(12 * W + 5, 0, 0, 1'b0);
    runPixels(W * H, 20, 37, 1'b1);

    $display("[TB] reset mid-frame at row 15");
    runPixels(15 * W + 11, 0, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    nAsserts++;
    assert (bus.win_valid === 1'b0) else begin
      nFails++; $error("[TB] FAIL async_reset_win_valid obs=%0b exp=0", bus.win_valid);
    end
    nAsserts++;
    assert (bus.frame_done === 1'b0) else begin
      nFails++; $error("[TB] FAIL async_reset_frame_done obs=%0b exp=0", bus.frame_done);
    end
    nAsserts++;
    assert (bus.win_out === '0) else begin
      nFails++; $error("[TB] FAIL async_reset_win_out obs=%h exp=0", bus.win_out);
    end
    bus.pix_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n       = 1'b1;
    mr          = 0;
    mc          = 0;
    acceptIdx   = 0;
    dutWins     = 0;
    expWinKnown = 1'b0;
    runPixels(W * H, 10, 5, 1'b0);

    @(negedge clk);
    bus.pix_valid = 1'b0;
    bus.sof       = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end
endmodule
